// File: rtl/sprite_rom_cache.sv
// Direct-mapped 64-bit read cache between the sprite-ROM fetch port and the SDRAM controller.
// Define SPRITE_CACHE_STATS_EN to build the saturating hit/miss statistics counters.
module sprite_rom_cache #(
  parameter int unsigned INDEX_BITS = 8
) (
  input  logic        CLK_96M,
  input  logic        RESET_N,
  input  logic        FLUSH,
  input  logic [24:0] sdr_addr,
  input  logic        sdr_req,
  output logic [63:0] sdr_data,
  output logic        sdr_rdy,
  output logic [24:0] mem_addr,
  output logic        mem_req,
  input  logic [63:0] mem_data,
  input  logic        mem_rdy,
  output logic        BUSY,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);
  localparam int unsigned ADDR_W = 25;
  localparam int unsigned WORD_W = 22;
  localparam int unsigned TAG_W  = WORD_W - INDEX_BITS;
  localparam int unsigned LINES  = 1 << INDEX_BITS;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [2:0] {
    SWEEP, IDLE, LOOKUP, COMPARE, MISS_REQ, MISS_GUARD, MISS_WAIT
  } state_t;

  state_t                  state_q, state_d;
  logic [WORD_W-1:0]       word_q, word_d;
  logic [INDEX_BITS-1:0]   sweep_idx_q, sweep_idx_d;
  logic                    req_pend_q, req_pend_d;
  logic                    flush_pend_q, flush_pend_d;
  logic                    mem_sync_q, mem_sync_d;
  logic [DATA_W-1:0]       sdr_data_q, sdr_data_d;
  logic                    sdr_rdy_q, sdr_rdy_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic                    mem_req_q, mem_req_d;
  logic                    busy_q, busy_d;

  logic [TAG_W:0]          tag_ram [LINES];
  logic [DATA_W-1:0]       data_ram [LINES];
  logic [TAG_W:0]          tag_rd_q;
  logic [DATA_W-1:0]       data_rd_q;
  logic                    tag_we, data_we;
  logic [INDEX_BITS-1:0]   wr_idx;
  logic [TAG_W:0]          tag_wr;
  logic [INDEX_BITS-1:0]   line_idx;
  logic [TAG_W-1:0]        line_tag;
  logic                    hit, to_idle, hit_inc, miss_inc;
  logic                    unused_addr;

  assign line_idx    = word_q[INDEX_BITS-1:0];
  assign line_tag    = word_q[WORD_W-1:INDEX_BITS];
  assign hit         = tag_rd_q[TAG_W] && (tag_rd_q[TAG_W-1:0] == line_tag);
  assign unused_addr = ^sdr_addr[2:0];

  // Tag/data RAMs: synchronous read of the latched line, single write port each.
  always_ff @(posedge CLK_96M) begin
    if (tag_we)  tag_ram[wr_idx]    <= tag_wr;
    if (data_we) data_ram[line_idx] <= mem_data;
    tag_rd_q  <= tag_ram[line_idx];
    data_rd_q <= data_ram[line_idx];
  end

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    sweep_idx_d  = sweep_idx_q;
    req_pend_d   = req_pend_q;
    flush_pend_d = flush_pend_q | FLUSH;
    mem_sync_d   = mem_sync_q | mem_rdy;
    sdr_data_d   = sdr_data_q;
    sdr_rdy_d    = sdr_rdy_q;
    mem_addr_d   = mem_addr_q;
    mem_req_d    = 1'b0;
    tag_we       = 1'b0;
    data_we      = 1'b0;
    wr_idx       = line_idx;
    tag_wr       = {1'b1, line_tag};
    to_idle      = 1'b0;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;
    case (state_q)
      SWEEP: begin
        tag_we      = 1'b1;
        wr_idx      = sweep_idx_q;
        tag_wr      = '0;
        sweep_idx_d = sweep_idx_q + INDEX_BITS'(1);
        if (sdr_req && !req_pend_q) begin
          req_pend_d = 1'b1;
          word_d     = sdr_addr[24:3];
          sdr_rdy_d  = 1'b0;
        end
        if (sweep_idx_q == INDEX_BITS'(LINES - 1)) begin
          if (flush_pend_d) begin
            flush_pend_d = 1'b0;
          end else if (req_pend_d) begin
            req_pend_d = 1'b0;
            state_d    = LOOKUP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      IDLE: begin
        if (sdr_req) begin
          word_d    = sdr_addr[24:3];
          sdr_rdy_d = 1'b0;
        end
        if (FLUSH) begin
          state_d      = SWEEP;
          sweep_idx_d  = '0;
          flush_pend_d = 1'b0;
          req_pend_d   = sdr_req;
        end else if (sdr_req) begin
          state_d = LOOKUP;
        end
      end
      LOOKUP: state_d = COMPARE;
      COMPARE: begin
        if (hit) begin
          sdr_data_d = data_rd_q;
          sdr_rdy_d  = 1'b1;
          hit_inc    = 1'b1;
          to_idle    = 1'b1;
        end else if (mem_sync_d) begin
          // Until mem_rdy has been seen high once after reset, a stale SDRAM access may be in flight.
          mem_req_d  = 1'b1;
          mem_addr_d = {word_q, 3'b000};
          miss_inc   = 1'b1;
          state_d    = MISS_REQ;
        end
      end
      // mem_rdy seen during the request cycle is left over from the previous access.
      MISS_REQ: state_d = MISS_GUARD;
      MISS_GUARD, MISS_WAIT: begin
        if (mem_rdy) begin
          tag_we     = 1'b1;
          data_we    = 1'b1;
          sdr_data_d = mem_data;
          sdr_rdy_d  = 1'b1;
          to_idle    = 1'b1;
        end else begin
          state_d = MISS_WAIT;
        end
      end
      default: state_d = SWEEP;
    endcase
    if (to_idle) begin
      if (flush_pend_d) begin
        state_d      = SWEEP;
        sweep_idx_d  = '0;
        flush_pend_d = 1'b0;
      end else begin
        state_d = IDLE;
      end
    end
    busy_d = (state_d == SWEEP);
  end

  always_ff @(posedge CLK_96M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= SWEEP;
      word_q       <= '0;
      sweep_idx_q  <= '0;
      req_pend_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      mem_sync_q   <= 1'b0;
      sdr_data_q   <= '0;
      sdr_rdy_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_req_q    <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      sweep_idx_q  <= sweep_idx_d;
      req_pend_q   <= req_pend_d;
      flush_pend_q <= flush_pend_d;
      mem_sync_q   <= mem_sync_d;
      sdr_data_q   <= sdr_data_d;
      sdr_rdy_q    <= sdr_rdy_d;
      mem_addr_q   <= mem_addr_d;
      mem_req_q    <= mem_req_d;
      busy_q       <= busy_d;
    end
  end

  assign sdr_data = sdr_data_q;
  assign sdr_rdy  = sdr_rdy_q;
  assign mem_addr = mem_addr_q;
  assign mem_req  = mem_req_q;
  assign BUSY     = busy_q;

`ifdef SPRITE_CACHE_STATS_EN
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  // Saturating statistics, cleared by FLUSH.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (FLUSH) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else begin
      if (hit_inc && (hit_cnt_q != '1))   hit_cnt_d  = hit_cnt_q + CNT_W'(1);
      if (miss_inc && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK_96M or negedge RESET_N) begin
    if (!RESET_N) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = hit_inc ^ miss_inc;
  assign hit_count    = CNT_W'(0);
  assign miss_count   = CNT_W'(0);
`endif

endmodule

// File: tb/tb_sprite_rom_cache.sv
// Bench for sprite_rom_cache: directed plan steps plus random reads against a line-level cache model.
module tb_sprite_rom_cache;
  logic        CLK_96M = 1'b0;
  logic        RESET_N = 1'b0;
  logic        FLUSH = 1'b0;
  logic [24:0] sdr_addr = '0;
  logic        sdr_req = 1'b0;
  logic [63:0] sdr_data;
  logic        sdr_rdy;
  logic [24:0] mem_addr;
  logic        mem_req;
  logic [63:0] mem_data = '0;
  logic        mem_rdy = 1'b1;
  logic        BUSY;
  logic [15:0] hit_count, miss_count;

  int vectors = 0;
  int miscompares = 0;

  sprite_rom_cache dut (
    .CLK_96M(CLK_96M), .RESET_N(RESET_N), .FLUSH(FLUSH),
    .sdr_addr(sdr_addr), .sdr_req(sdr_req), .sdr_data(sdr_data), .sdr_rdy(sdr_rdy),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_data(mem_data), .mem_rdy(mem_rdy),
    .BUSY(BUSY), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK_96M = ~CLK_96M;

  function automatic logic [63:0] mem_word(input logic [21:0] w);
    if (w == 22'h000247) return 64'hDEADBEEF_01234567;
    return {w, 10'h155, w ^ 22'h2AAAAA, 10'h0AA};
  endfunction

  // SDRAM model: rdy drops when a request is taken and returns mem_lat edges later.
  int          mem_lat = 3;
  bit          hold_rdy = 1'b0;
  int          m_cnt = 0;
  logic [24:0] m_addr_l = '0;
  int          mreq_cnt = 0;
  int          viol = 0;

  always @(posedge CLK_96M) begin
    if (mem_req) begin
      mreq_cnt <= mreq_cnt + 1;
      if (!mem_rdy) viol <= viol + 1;
      if (hold_rdy) begin
        mem_data <= mem_word(mem_addr[24:3]);
        mem_rdy  <= 1'b1;
      end else begin
        mem_rdy  <= 1'b0;
        m_cnt    <= mem_lat;
        m_addr_l <= mem_addr;
      end
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        mem_rdy  <= 1'b1;
        mem_data <= mem_word(m_addr_l[24:3]);
      end
    end
  end

  // Reference cache: one valid bit and tag per line, plus statistics.
  bit        m_valid [256];
  bit [13:0] m_tag [256];
  int        m_hits = 0;
  int        m_misses = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic check_stats();
`ifdef SPRITE_CACHE_STATS_EN
    check("hit_count", 64'(hit_count), 64'(m_hits));
    check("miss_count", 64'(miss_count), 64'(m_misses));
`else
    check("hit_count", 64'(hit_count), 64'd0);
    check("miss_count", 64'(miss_count), 64'd0);
`endif
  endtask

  task automatic wait_sweep();
    int n;
    n = 0;
    check("busy_high", 64'(BUSY), 64'd1);
    while (BUSY && n < 1000) begin
      @(posedge CLK_96M); #1;
      n++;
    end
    check("sweep_cycles", 64'(n), 64'd256);
  endtask

  task automatic flush_idle();
    @(negedge CLK_96M);
    FLUSH = 1'b1;
    @(posedge CLK_96M); #1;
    FLUSH = 1'b0;
    clear_model();
    wait_sweep();
  endtask

  // One read; k counts edges after the one that sampled sdr_req (E0).
  task automatic do_read(input logic [24:0] a, input int lat, input int flush_at, input bit chk_lat);
    logic [21:0] w;
    logic [7:0]  ix;
    logic [13:0] tg;
    bit          hit, flushed;
    int          k, req0, exp_k;
    w  = a[24:3];
    ix = w[7:0];
    tg = w[21:8];
    hit = m_valid[ix] && (m_tag[ix] == tg);
    mem_lat = lat;
    flushed = 1'b0;
    @(negedge CLK_96M);
    sdr_addr = a;
    sdr_req  = 1'b1;
    req0     = mreq_cnt;
    @(negedge CLK_96M);
    sdr_req  = 1'b0;
    sdr_addr = 25'($urandom);
    check("rdy_low_after_req", 64'(sdr_rdy), 64'd0);
    k = 0;
    while (!sdr_rdy && k < 800) begin
      if (k == flush_at) begin
        FLUSH   = 1'b1;
        flushed = 1'b1;
      end
      @(negedge CLK_96M);
      FLUSH = 1'b0;
      k++;
    end
    check("rdy_timeout", 64'(k < 800), 64'd1);
    exp_k = hit ? 2 : (hold_rdy ? 4 : 4 + lat);
    if (chk_lat) check(hit ? "hit_latency" : "miss_latency", 64'(k), 64'(exp_k));
    check("read_data", sdr_data, mem_word(w));
    check("mem_req_count", 64'(mreq_cnt - req0), hit ? 64'd1 - 64'd1 : 64'd1);
    if (!hit) check("mem_addr", 64'(mem_addr), 64'({w, 3'b000}));
    if (hit) m_hits = (m_hits == 65535) ? m_hits : m_hits + 1;
    else     m_misses = (m_misses == 65535) ? m_misses : m_misses + 1;
    m_valid[ix] = 1'b1;
    m_tag[ix]   = tg;
    if (flushed) clear_model();
    check_stats();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed hang expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [21:0] w;
    logic [24:0] a;
    clear_model();

    repeat (3) @(negedge CLK_96M);
    check("rst_sdr_rdy", 64'(sdr_rdy), 64'd0);
    check("rst_sdr_data", sdr_data, 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_busy", 64'(BUSY), 64'd1);
    check_stats();
    RESET_N = 1'b1;
    wait_sweep();
    check("rdy_idle_after_sweep", 64'(sdr_rdy), 64'd0);

    do_read(25'h0001238, 5, -1, 1'b1);
    do_read(25'h0001238, 5, -1, 1'b1);
    do_read(25'h0009238, 3, -1, 1'b1);
    do_read(25'h0001238, 2, -1, 1'b1);

    do_read(25'h00002A0, 5, 3, 1'b1);
    wait_sweep();
    do_read(25'h00002A0, 2, -1, 1'b1);

    hold_rdy = 1'b1;
    do_read(25'h0777000, 1, -1, 1'b1);
    do_read(25'h0777000, 1, -1, 1'b1);
    hold_rdy = 1'b0;

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) flush_idle();
      w = {14'($urandom_range(0, 2)), 8'($urandom_range(16, 18))};
      a = {w, 3'($urandom)};
      do_read(a, int'($urandom_range(1, 6)), -1, 1'b1);
    end

    // Reset during an outstanding miss whose SDRAM response outlives the sweep.
    mem_lat = 300;
    @(negedge CLK_96M);
    sdr_addr = 25'h1ABCDE8;
    sdr_req  = 1'b1;
    @(negedge CLK_96M);
    sdr_req = 1'b0;
    repeat (6) @(negedge CLK_96M);
    RESET_N = 1'b0;
    #1;
    check("midrst_sdr_rdy", 64'(sdr_rdy), 64'd0);
    check("midrst_sdr_data", sdr_data, 64'd0);
    check("midrst_mem_req", 64'(mem_req), 64'd0);
    check("midrst_busy", 64'(BUSY), 64'd1);
    clear_model();
    repeat (2) @(negedge CLK_96M);
    RESET_N = 1'b1;
    wait_sweep();
    check("stale_sdram_busy", 64'(mem_rdy), 64'd0);
    do_read(25'h1ABCDE8, 3, -1, 1'b0);
    do_read(25'h1ABCDE8, 3, -1, 1'b1);
    check("mem_req_while_busy", 64'(viol), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
